// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: default operand
// width and the controller state encoding.
package serial_add_pkg;

   // Operand/result width used when the instantiating level does not override it.
   localparam int DEFAULT_WIDTH = 8;

   // State encodings, kept as named constants so other blocks can decode them.
   localparam logic [1:0] IDLE_ENC = 2'd0;
   localparam logic [1:0] RUN_ENC  = 2'd1;
   localparam logic [1:0] DONE_ENC = 2'd2;

   typedef enum logic [1:0] {
      IDLE = IDLE_ENC,
      RUN  = RUN_ENC,
      DONE = DONE_ENC
   } state_t;

   // Counter width needed to index WIDTH bit positions (never below one bit).
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder
// controller (slave). Operands and start flow in; status and result flow out.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   // Requester side: issues operands and watches for completion.
   modport master (
      output start,
      output a,
      output b,
      output cin,
      input  busy,
      input  done,
      input  sum,
      input  cout
   );

   // Controller side: consumes operands and reports the result.
   modport slave (
      input  start,
      input  a,
      input  b,
      input  cin,
      output busy,
      output done,
      output sum,
      output cout
   );

endinterface

// File: rtl/serial_add_ctrl_full_add.sv
// Decoder-based 3-input full adder. The three inputs are decoded into one of
// eight minterms and the sum/carry outputs are ORs of the matching minterms.
// Purely combinational; no state.
module full_add (
   input  logic A,
   input  logic B,
   input  logic Ci,
   output logic S,
   output logic Co
);

   logic [7:0] minterm;

   // One-hot decode of the input triple {A,B,Ci}.
   always_comb begin
      minterm = 8'b0;
      minterm[{A, B, Ci}] = 1'b1;
   end

   // Sum is odd parity of the inputs; carry is the majority function.
   always_comb begin
      S  = minterm[1] | minterm[2] | minterm[4] | minterm[7];
      Co = minterm[3] | minterm[5] | minterm[6] | minterm[7];
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller. Captures a, b and cin on an accepted
// start, then feeds one bit pair plus the running carry to the full adder per
// clock, LSB first. The adder's sum bits are shifted into a collection
// register from the top, so after WIDTH steps the result sits in natural
// order. The published sum/cout only change on the completion edge.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_add_ctrl_if.slave   bus
);

   localparam int              CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   // Only the upper WIDTH-1 collected bits need storage: the final bit goes
   // straight from the adder into the published result on the last edge.
   logic [WIDTH-2:0] sum_sh;
   logic [WIDTH-1:0] sum_cat;

   logic [WIDTH-1:0] sum_reg;
   logic             cout_reg;

   logic             fa_s;
   logic             fa_co;

   logic             load;
   logic             step;
   logic             last;

   // The only arithmetic in this block lives in the full adder.
   full_add u_full_add (
      .A  (a_sh[0]),
      .B  (b_sh[0]),
      .Ci (carry),
      .S  (fa_s),
      .Co (fa_co)
   );

   // Newest sum bit enters at the MSB, older bits move one place right.
   assign sum_cat = {fa_s, sum_sh};

   // State register; reset returns to IDLE and abandons any partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control: accept start only when idle, step once
   // per clock while running, and spend exactly one cycle in DONE.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == LAST_CNT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand shifters, carry, bit counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         sum_sh   <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
      end else if (load) begin
         a_sh   <= bus.a;
         b_sh   <= bus.b;
         carry  <= bus.cin;
         cnt    <= '0;
      end else if (step) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         carry  <= fa_co;
         sum_sh <= sum_cat[WIDTH-1:1];
         if (last) begin
            sum_reg  <= sum_cat;
            cout_reg <= fa_co;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Status decodes straight from the state so reset clears them immediately.
   always_comb begin
      bus.busy = (state != IDLE);
      bus.done = (state == DONE);
      bus.sum  = sum_reg;
      bus.cout = cout_reg;
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl. Expected results come from plain
// integer addition of the operands; expected timing comes from the documented
// edge schedule (result at WIDTH edges after the accepting edge).
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus_i ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {cout,sum} = a + b + cin in WIDTH+1 bits.
   function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   endfunction

   // Issue one operation and observe it until well after completion.
   // lat: edge index (after the accepting edge) where done was first seen.
   task automatic run_op(input  logic [WIDTH-1:0] a,
                         input  logic [WIDTH-1:0] b,
                         input  logic             cin,
                         output int               lat,
                         output int               pulses,
                         output logic [WIDTH-1:0] rsum,
                         output logic             rcout,
                         output logic             held_ok,
                         output logic             busy_ok);
      logic [WIDTH-1:0] prev_sum;
      logic             prev_cout;
      @(negedge clk);
      bus_i.a     = a;
      bus_i.b     = b;
      bus_i.cin   = cin;
      bus_i.start = 1'b1;
      prev_sum    = bus_i.sum;
      prev_cout   = bus_i.cout;
      @(posedge clk);
      #1;
      bus_i.start = 1'b0;
      busy_ok = (bus_i.busy === 1'b1);
      held_ok = 1'b1;
      lat     = -1;
      pulses  = 0;
      rsum    = 'x;
      rcout   = 1'bx;
      for (int k = 1; k <= WIDTH + 3; k++) begin
         @(posedge clk);
         #1;
         if (bus_i.done === 1'b1) begin
            pulses++;
            if (lat < 0) begin
               lat   = k;
               rsum  = bus_i.sum;
               rcout = bus_i.cout;
            end
         end
         if (lat < 0 && (bus_i.sum !== prev_sum || bus_i.cout !== prev_cout))
            held_ok = 1'b0;
         if ((k <= WIDTH) ? (bus_i.busy !== 1'b1) : (bus_i.busy !== 1'b0))
            busy_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus_i.start = 1'b0;
      bus_i.a     = '0;
      bus_i.b     = '0;
      bus_i.cin   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({bus_i.busy, bus_i.done, bus_i.cout, bus_i.sum} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs got busy=%b done=%b cout=%b sum=%h want all 0",
                  bus_i.busy, bus_i.done, bus_i.cout, bus_i.sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (bus_i.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL idle_after_reset busy=%b want 0", bus_i.busy);
      end
   endtask

   // One directed operation with full timing, result and busy/hold checks.
   task automatic check_op(input string name,
                           input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b,
                           input logic cin);
      int               lat, pulses;
      logic [WIDTH-1:0] rsum;
      logic             rcout, held_ok, busy_ok;
      logic [WIDTH:0]   exp;
      exp = model_add(a, b, cin);
      run_op(a, b, cin, lat, pulses, rsum, rcout, held_ok, busy_ok);
      vectors++;
      if ({rcout, rsum} !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s_result got cout=%b sum=%h want cout=%b sum=%h",
                  name, rcout, rsum, exp[WIDTH], exp[WIDTH-1:0]);
      end
      vectors++;
      if (lat !== WIDTH || pulses !== 1) begin
         miscompares++;
         $display("[TB] FAIL %s_timing got latency=%0d pulses=%0d want latency=%0d pulses=1",
                  name, lat, pulses, WIDTH);
      end
      vectors++;
      if (!busy_ok || !held_ok) begin
         miscompares++;
         $display("[TB] FAIL %s_busy_hold got busy_ok=%b held_ok=%b want 1 1",
                  name, busy_ok, held_ok);
      end
   endtask

   task automatic test_directed();
      check_op("hex5a_3c", 8'h5A, 8'h3C, 1'b0);
      check_op("ripple_ff_01", 8'hFF, 8'h01, 1'b0);
   endtask

   task automatic test_back_to_back();
      check_op("max_cin", 8'hFF, 8'hFF, 1'b1);
      check_op("zero_after_max", 8'h00, 8'h00, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         check_op("random", WIDTH'($urandom_range(0, 255)),
                  WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_start_ignored();
      int             pulses, lat;
      logic [WIDTH:0] exp;
      logic [WIDTH:0] got;
      exp    = model_add(8'h12, 8'h34, 1'b0);
      pulses = 0;
      lat    = -1;
      got    = 'x;
      @(negedge clk);
      bus_i.a = 8'h12; bus_i.b = 8'h34; bus_i.cin = 1'b0; bus_i.start = 1'b1;
      @(posedge clk);
      #1;
      bus_i.start = 1'b0;
      for (int k = 1; k <= WIDTH + 4; k++) begin
         @(posedge clk);
         #1;
         if (bus_i.done === 1'b1) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               got = {bus_i.cout, bus_i.sum};
            end
         end
         if (k == 2) begin
            bus_i.a = 8'hFF; bus_i.start = 1'b1;
         end
         if (k == 3) begin
            bus_i.a = 8'h12; bus_i.start = 1'b0;
         end
      end
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL ignore_start_result got %h want %h", got, exp);
      end
      vectors++;
      if (pulses !== 1 || lat !== WIDTH) begin
         miscompares++;
         $display("[TB] FAIL ignore_start_pulses got pulses=%0d latency=%0d want 1 %0d",
                  pulses, lat, WIDTH);
      end
      vectors++;
      if (bus_i.busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL ignore_start_idle busy=%b want 0", bus_i.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      bus_i.a = 8'hA7; bus_i.b = 8'h6E; bus_i.cin = 1'b1; bus_i.start = 1'b1;
      @(posedge clk);
      #1;
      bus_i.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus_i.busy, bus_i.done, bus_i.cout, bus_i.sum} !== '0) begin
         miscompares++;
         $display("[TB] FAIL async_reset got busy=%b done=%b cout=%b sum=%h want all 0",
                  bus_i.busy, bus_i.done, bus_i.cout, bus_i.sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      check_op("after_reset", 8'hC3, 8'h5D, 1'b1);
   endtask

   task automatic test_held_start();
      logic [WIDTH:0] exp;
      int             pulses;
      exp    = model_add(8'h81, 8'h7F, 1'b0);
      pulses = 0;
      @(negedge clk);
      bus_i.a = 8'h81; bus_i.b = 8'h7F; bus_i.cin = 1'b0; bus_i.start = 1'b1;
      for (int idx = 0; idx < 30; idx++) begin
         @(posedge clk);
         #1;
         if (bus_i.done === 1'b1) pulses++;
         vectors++;
         if (bus_i.done !== (idx % 10 == 8) || bus_i.busy !== (idx % 10 != 9)) begin
            miscompares++;
            $display("[TB] FAIL held_start_edge%0d got done=%b busy=%b want done=%b busy=%b",
                     idx, bus_i.done, bus_i.busy, (idx % 10 == 8), (idx % 10 != 9));
         end
      end
      bus_i.start = 1'b0;
      vectors++;
      if (pulses !== 3 || {bus_i.cout, bus_i.sum} !== exp) begin
         miscompares++;
         $display("[TB] FAIL held_start_summary got pulses=%0d result=%h want 3 %h",
                  pulses, {bus_i.cout, bus_i.sum}, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid_run();
      test_held_start();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
